code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Writer side of the CPU instruction-store interface: receives a framed byte stream and writes 16-bit instruction words into the code RAM the CPU fetches from.
- Holds the CPU in reset while loading; releases it only after a frame with a valid checksum.
- Sits between a byte source (serial receiver or test host) and the code RAM write port plus the CPU reset input.

Parameters:
- ADDR_W, 16, code RAM address width.
- BASE_ADDR, 0, address of the first word written.
- MAX_WORDS, 256, largest accepted word count; larger counts are errors.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout limit; used only with CODE_LOADER_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  byte-source data.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at posedge.
- wr_en  out  1  code RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_W  code RAM write address.
- wr_data  out  16  code RAM write data.
- cpu_run  out  1  1 = CPU released; 0 = CPU held in reset. Drives the CPU reset pin directly.
- done  out  1  level; last frame loaded with good checksum.
- err  out  1  level; last frame failed.

Behaviour:
- Reset (async, reset=0): state IDLE, in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_run=0, done=0, err=0, internal counters and checksum cleared. Reset mid-frame abandons the frame; words already written stay in RAM.
- Frame format: 0xA5 sync, count high byte, count low byte (N words), 2N payload bytes (each word high byte first), then 1 checksum byte equal to XOR of all payload bytes.
- States:
  - IDLE: discard bytes until 0xA5 is accepted -> LEN_HI. Clear done, err, checksum, word index; cpu_run=0.
  - LEN_HI: latch count[15:8] -> LEN_LO.
  - LEN_LO: latch count[7:0].
    - If N > MAX_WORDS -> ERR.
    - If N == 0 -> CHK.
    - Otherwise -> DATA_HI.
  - DATA_HI: latch high byte; XOR it into the checksum -> DATA_LO.
  - DATA_LO: latch low byte; XOR it into the checksum -> WRITE.
  - WRITE (one cycle): in_ready=0, wr_en=1, wr_data={hi,lo}, wr_addr=BASE_ADDR+index (mod 2^ADDR_W). Increment index. If index+1 == N -> CHK, else -> DATA_HI.
  - CHK: accepted byte equals checksum -> RUN (done=1); otherwise -> ERR (err=1). For N=0 the expected checksum is 0x00.
  - RUN: cpu_run=1 from the cycle after the good checksum byte is accepted. Non-sync bytes are discarded. Accepting 0xA5 drops cpu_run to 0 in the next cycle and goes to LEN_HI (reload).
  - ERR: cpu_run=0, err=1. Non-sync bytes are discarded; 0xA5 -> LEN_HI.
- in_ready is 1 in every state except WRITE. Peak throughput is 2 bytes per 3 cycles during payload.
- wr_addr holds its last value when wr_en=0. Only wr_en qualifies wr_addr and wr_data.
- Count is 16-bit unsigned. The word index is ADDR_W bits and wraps silently if BASE_ADDR+N exceeds the address space.

Optional Feature:
- Macro CODE_LOADER_TIMEOUT_EN.
- Defined: a counter runs in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. It clears on each accepted byte. When it reaches TIMEOUT_CYCLES with no accepted byte, the loader goes to ERR (err=1, cpu_run=0).
- Not defined: no counter; the loader waits indefinitely mid-frame. TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, RUN, ERR)
  - SYNC_BYTE=8'hA5
  - code word width 16
- One natural sub-module: code_loader_timeout, the timeout counter. Instantiated only under the macro.

Test Plan:
- Reset, then send A5 00 02 12 34 AB CD 40 -> wr_en pulses with (addr 0, data 0x1234) and (addr 1, data 0xABCD); cpu_run=1 and done=1 after the last byte; err=0.
- Same frame with checksum byte 41 -> both writes occur; err=1, cpu_run=0, done=0.
- A5 01 01 with MAX_WORDS=256 (N=257) -> ERR after the third byte; no wr_en.
- Frame A5 00 00 00 -> RUN with no writes. Then in RUN send 77 -> ignored. Then A5 -> cpu_run=0 next cycle, state LEN_HI.
- Assert reset after A5 00 01 12 -> all outputs return to reset values; a following good frame loads normally.
- With CODE_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20: send A5 00 and then idle 20 cycles -> err=1. Without the macro the same stimulus stays in LEN_LO with err=0.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared definitions for the code loader: FSM state encodings, sync byte, word width.
package code_loader_pkg;

  localparam int          WORD_W    = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_HI  = 4'd1;
  localparam logic [3:0] ST_LEN_LO  = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_WRITE   = 4'd5;
  localparam logic [3:0] ST_CHK     = 4'd6;
  localparam logic [3:0] ST_RUN     = 4'd7;
  localparam logic [3:0] ST_ERR     = 4'd8;

endpackage

// File: rtl/code_loader_timeout.sv
// Inter-byte timeout counter; only built when CODE_LOADER_TIMEOUT_EN is defined.
module code_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Fires on the cycle that would complete TIMEOUT_CYCLES idle cycles.
  assign expired = active && !kick && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!active || kick || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/code_loader.sv
// Framed byte stream -> 16-bit code RAM writes; holds the CPU in reset until a good checksum.
// Optional inter-byte timeout: define CODE_LOADER_TIMEOUT_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_N = 17'(MAX_WORDS);

  logic [3:0]  state;
  logic [15:0] count;
  logic [15:0] word_cnt;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic        accept;
  logic        is_sync;
  logic        timeout_hit;
  logic [15:0] len_now;

  assign in_ready = (state != ST_WRITE);
  assign wr_en    = (state == ST_WRITE);
  assign accept   = in_valid && in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign len_now  = {count[15:8], in_data};

`ifdef CODE_LOADER_TIMEOUT_EN
  logic timeout_active;

  assign timeout_active = (state == ST_LEN_HI)  || (state == ST_LEN_LO) ||
                          (state == ST_DATA_HI) || (state == ST_DATA_LO) ||
                          (state == ST_CHK);

  code_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .active (timeout_active),
    .kick   (accept),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      word_cnt <= '0;
      hi_byte  <= '0;
      csum     <= '0;
      wr_addr  <= BASE;
      wr_data  <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (timeout_hit) begin
      state   <= ST_ERR;
      err     <= 1'b1;
      cpu_run <= 1'b0;
    end else begin
      case (state)
        // A sync byte starts a (re)load from any resting state.
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (accept && is_sync) begin
            state    <= ST_LEN_HI;
            done     <= 1'b0;
            err      <= 1'b0;
            csum     <= '0;
            word_cnt <= '0;
            cpu_run  <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            if ({1'b0, len_now} > MAX_N) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else if (len_now == 16'd0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
            state   <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            wr_data <= {hi_byte, in_data};
            wr_addr <= BASE + ADDR_W'(word_cnt);
            csum    <= csum ^ in_data;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt + 16'd1;
          state    <= (word_cnt + 16'd1 == count) ? ST_CHK : ST_DATA_HI;
        end
        ST_CHK: begin
          if (accept) begin
            if (in_data == csum) begin
              state   <= ST_RUN;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader (timeout expectation follows CODE_LOADER_TIMEOUT_EN).
module tb_code_loader;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_run;
  logic        done;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [7:0]  frm[$];

  always #5 clock = ~clock;

  code_loader #(
    .ADDR_W        (16),
    .BASE_ADDR     (0),
    .MAX_WORDS     (256),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_run (cpu_run),
    .done    (done),
    .err     (err)
  );

  // Capture every write away from the active edge.
  always @(negedge clock) begin
    if (reset && wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at a later negedge after the byte has transferred.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send(frm[i]);
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({pfx, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check({pfx, "_wr_addr"},  {16'd0, wr_addr},  32'd0);
    check({pfx, "_wr_data"},  {16'd0, wr_data},  32'd0);
    check({pfx, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
    check({pfx, "_done"},     {31'd0, done},     32'd0);
    check({pfx, "_err"},      {31'd0, err},      32'd0);
  endtask

  initial begin
    logic [7:0] ck;
    logic [7:0] hi;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clock);

    // Two-word frame, good checksum 12^34^AB^CD = 40.
    clear_writes();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frm();
    check("good_nwr",   wa_q.size(), 32'd2);
    check("good_a0",    {16'd0, wa_q[0]}, 32'h0000);
    check("good_d0",    {16'd0, wd_q[0]}, 32'h1234);
    check("good_a1",    {16'd0, wa_q[1]}, 32'h0001);
    check("good_d1",    {16'd0, wd_q[1]}, 32'hABCD);
    check("good_run",   {31'd0, cpu_run}, 32'd1);
    check("good_done",  {31'd0, done},    32'd1);
    check("good_err",   {31'd0, err},     32'd0);

    // Same frame, bad checksum.
    clear_writes();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frm();
    check("bad_nwr",  wa_q.size(), 32'd2);
    check("bad_d1",   {16'd0, wd_q[1]}, 32'hABCD);
    check("bad_err",  {31'd0, err},     32'd1);
    check("bad_run",  {31'd0, cpu_run}, 32'd0);
    check("bad_done", {31'd0, done},    32'd0);

    // Oversize count N=257.
    clear_writes();
    frm = '{8'hA5, 8'h01, 8'h01};
    send_frm();
    check("big_err",  {31'd0, err},  32'd1);
    check("big_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clock);
    check("big_nwr",  wa_q.size(), 32'd0);

    // Empty frame, then a stray byte in RUN, then reload.
    clear_writes();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frm();
    check("empty_run",  {31'd0, cpu_run}, 32'd1);
    check("empty_done", {31'd0, done},    32'd1);
    check("empty_nwr",  wa_q.size(), 32'd0);
    send(8'h77);
    check("stray_run",  {31'd0, cpu_run}, 32'd1);
    check("stray_done", {31'd0, done},    32'd1);
    send(8'hA5);
    check("reload_run", {31'd0, cpu_run}, 32'd0);
    frm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'h11};
    send_frm();
    check("reload_nwr", wa_q.size(), 32'd1);
    check("reload_d0",  {16'd0, wd_q[0]}, 32'hAABB);
    check("reload_done", {31'd0, done},   32'd1);

    // Reset mid-frame, then a normal frame.
    frm = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_frm();
    reset = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    clear_writes();
    frm = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'h2E};
    send_frm();
    check("post_nwr",  wa_q.size(), 32'd1);
    check("post_a0",   {16'd0, wa_q[0]}, 32'h0000);
    check("post_d0",   {16'd0, wd_q[0]}, 32'h5678);
    check("post_done", {31'd0, done},    32'd1);

    // Largest legal frame: N = MAX_WORDS = 256.
    clear_writes();
    ck = 8'h00;
    frm = '{8'hA5, 8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i * 7 + 1);
      frm.push_back(hi);
      frm.push_back(8'(i));
      ck = ck ^ hi ^ 8'(i);
    end
    frm.push_back(ck);
    send_frm();
    check("max_nwr",  wa_q.size(), 32'd256);
    check("max_a255", {16'd0, wa_q[255]}, 32'h00FF);
    check("max_d255", {16'd0, wd_q[255]}, {16'd0, 8'(255 * 7 + 1), 8'hFF});
    check("max_done", {31'd0, done}, 32'd1);

    // Stall mid-frame after A5 00.
    frm = '{8'hA5, 8'h00};
    send_frm();
    repeat (25) @(negedge clock);
`ifdef CODE_LOADER_TIMEOUT_EN
    check("tmo_err", {31'd0, err}, 32'd1);
`else
    check("tmo_err", {31'd0, err}, 32'd0);
`endif
    check("tmo_run", {31'd0, cpu_run}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
